// File: rtl/normalizer.sv
// Sequential leading-zero normalizer: a 4-step binary search (8, 4, 2, 1 bits),
// one step per clock, producing In << Cnt and the leading-zero count Cnt.
module normalizer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] In,
  output logic        busy,
  output logic        done,
  output logic [15:0] Out,
  output logic [3:0]  Cnt,
  output logic        zero
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S8   = 3'd1,
    S4   = 3'd2,
    S2   = 3'd3,
    S1   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] work_q, work_d;
  logic [3:0]  acc_q, acc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] out_q, out_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        zero_q, zero_d;

  // Result of the current search step, used both to advance the search and,
  // in S1, as the final value registered into the outputs.
  logic [15:0] step_work;
  logic [3:0]  step_acc;

  always_comb begin
    step_work = work_q;
    step_acc  = acc_q;
    unique case (state_q)
      S8: if (work_q[15:8] == 8'h00) begin
            step_work = {work_q[7:0], 8'h00};
            step_acc  = acc_q + 4'd8;
          end
      S4: if (work_q[15:12] == 4'h0) begin
            step_work = {work_q[11:0], 4'h0};
            step_acc  = acc_q + 4'd4;
          end
      S2: if (work_q[15:14] == 2'b00) begin
            step_work = {work_q[13:0], 2'b00};
            step_acc  = acc_q + 4'd2;
          end
      S1: if (!work_q[15]) begin
            step_work = {work_q[14:0], 1'b0};
            step_acc  = acc_q + 4'd1;
          end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: if (start) begin
              work_d  = In;
              acc_d   = '0;
              busy_d  = 1'b1;
              state_d = S8;
            end
      S8: begin
            work_d  = step_work;
            acc_d   = step_acc;
            state_d = S4;
          end
      S4: begin
            work_d  = step_work;
            acc_d   = step_acc;
            state_d = S2;
          end
      S2: begin
            work_d  = step_work;
            acc_d   = step_acc;
            state_d = S1;
          end
      S1: begin
            // A zero operand ends with acc=15; report count 0 instead.
            work_d  = step_work;
            acc_d   = step_acc;
            out_d   = step_work;
            zero_d  = (step_work == 16'h0000);
            cnt_d   = (step_work == 16'h0000) ? 4'd0 : step_acc;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Out  = out_q;
  assign Cnt  = cnt_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_normalizer.sv
// Self-checking bench for normalizer: directed cases plus randomized operands
// checked against a bit-scan reference model.
module tb_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] In;
  logic        busy;
  logic        done;
  logic [15:0] Out;
  logic [3:0]  Cnt;
  logic        zero;

  int errors = 0;
  int checks = 0;

  normalizer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .In    (In),
    .busy  (busy),
    .done  (done),
    .Out   (Out),
    .Cnt   (Cnt),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  // Reference: count leading zeros by scanning from the MSB.
  function automatic logic [3:0] ref_cnt(input logic [15:0] v);
    int n = 0;
    if (v == 16'h0000) return 4'd0;
    while (v[15 - n] == 1'b0) n++;
    return 4'(n);
  endfunction

  function automatic logic [15:0] ref_out(input logic [15:0] v);
    return v << ref_cnt(v);
  endfunction

  // Drive start for one edge, leaving the bench at the negedge after acceptance.
  task automatic issue(input logic [15:0] v);
    start = 1'b1;
    In    = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count negedges until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_result(input string name, input logic [15:0] v);
    int n;
    issue(v);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy after accept: got %0b want 1", name, busy);
    end
    wait_done(n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL %s latency: got %0d want 4", name, n);
    end
    checks++;
    if (Out !== ref_out(v) || Cnt !== ref_cnt(v) || zero !== (v == 16'h0000) || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s In=%h: got Out=%h Cnt=%0d zero=%0b busy=%0b want Out=%h Cnt=%0d zero=%0b busy=0",
               name, v, Out, Cnt, zero, busy, ref_out(v), ref_cnt(v), (v == 16'h0000));
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done pulse width: got %0b want 0", name, done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; In = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Out !== 16'h0000 || Cnt !== 4'd0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset: got busy=%0b done=%0b Out=%h Cnt=%0d zero=%0b want all zero",
               busy, done, Out, Cnt, zero);
    end
  endtask

  task automatic test_directed;
    check_result("lsb", 16'h0001);
    check_result("msb", 16'h8000);
    check_result("nibble", 16'h00F0);
    check_result("mixed", 16'h1234);
    check_result("zero", 16'h0000);
    check_result("after_zero", 16'h4000);
  endtask

  task automatic test_random;
    logic [15:0] v;
    for (int i = 0; i < 40; i++) begin
      v = 16'($urandom) >> $urandom_range(0, 16);
      check_result("random", v);
    end
  endtask

  task automatic test_ignored_start;
    int n;
    int busy_cycles;
    int done_count;
    issue(16'h0100);
    start = 1'b1; In = 16'h0001;
    busy_cycles = 0; done_count = 0;
    for (int c = 0; c < 8; c++) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_count++;
        checks++;
        if (Cnt !== 4'd7 || Out !== 16'h8000) begin
          errors++;
          $display("FAIL ignored_start result: got Cnt=%0d Out=%h want Cnt=7 Out=8000", Cnt, Out);
        end
      end
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    n = done_count;
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL ignored_start done count: got %0d want 1", n);
    end
    checks++;
    if (busy_cycles !== 4) begin
      errors++;
      $display("FAIL ignored_start busy cycles: got %0d want 4", busy_cycles);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int unstable;
    issue(16'h1234);
    wait_done(n);
    checks++;
    if (done !== 1'b1 || Cnt !== 4'd3 || Out !== 16'h91A0) begin
      errors++;
      $display("FAIL b2b first: got done=%0b Cnt=%0d Out=%h want done=1 Cnt=3 Out=91a0", done, Cnt, Out);
    end
    start = 1'b1; In = 16'h0003;
    @(negedge clk);
    start = 1'b0;
    n = 1; unstable = 0;
    while (!done && n < 20) begin
      if (Out !== 16'h91A0 || Cnt !== 4'd3) unstable++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL b2b spacing: got %0d want 5", n);
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL b2b hold: got %0d changed cycles want 0", unstable);
    end
    checks++;
    if (Cnt !== 4'd14 || Out !== 16'hC000 || zero !== 1'b0) begin
      errors++;
      $display("FAIL b2b second: got Cnt=%0d Out=%h zero=%0b want Cnt=14 Out=c000 zero=0", Cnt, Out, zero);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int dones;
    issue(16'h0001);
    @(negedge clk);  // S8 step taken, now in S4
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Out !== 16'h0000 || Cnt !== 4'd0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%0b done=%0b Out=%h Cnt=%0d zero=%0b want all zero",
               busy, done, Out, Cnt, zero);
    end
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_mid spurious done: got %0d want 0", dones);
    end
    check_result("after_reset", 16'h0020);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_ignored_start;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
